// File: rtl/vmem_fill_engine_pkg.sv
// Shared constants, state type and clip helper for the vmem rectangle-fill engine.
package vmem_fill_engine_pkg;

  localparam int FILL_SEL_BIT = 29;

  localparam logic [1:0] FILL_POS   = 2'd0;
  localparam logic [1:0] FILL_SIZE  = 2'd1;
  localparam logic [1:0] FILL_COLOR = 2'd2;
  localparam logic [1:0] FILL_CTRL  = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_BUSY     = 0;
  localparam int CTRL_DONE     = 1;

  typedef enum logic {S_IDLE, S_RUN} fill_state_e;

  // min(org+len, lim); the sum can reach 766, so it is formed in 10 bits first.
  function automatic logic [8:0] clip_end(input logic [7:0] org, input logic [8:0] len,
                                          input logic [8:0] lim);
    logic [9:0] w_sum;
    w_sum = {2'b00, org} + {1'b0, len};
    return (w_sum > {1'b0, lim}) ? lim : w_sum[8:0];
  endfunction

endpackage

// File: rtl/vmem_fill_engine_raster.sv
// Raster cursor for the fill engine: walks x0..x_end-1 per row and flags the final pixel.
module vmem_fill_raster (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_load,
  input  logic [7:0] i_x0,
  input  logic [7:0] i_y0,
  input  logic [8:0] i_x_end,
  input  logic [8:0] i_y_end,
  input  logic       i_advance,
  output logic [7:0] o_cx,
  output logic [7:0] o_cy,
  output logic       o_last
);

  logic [7:0] r_cx;
  logic [7:0] r_cy;
  logic       w_x_wrap;

  assign w_x_wrap = (({1'b0, r_cx} + 9'd1) == i_x_end);
  assign o_last   = w_x_wrap && (({1'b0, r_cy} + 9'd1) == i_y_end);
  assign o_cx     = r_cx;
  assign o_cy     = r_cy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_load) begin
      r_cx <= i_x0;
      r_cy <= i_y0;
    end else if (i_advance) begin
      if (w_x_wrap) begin
        r_cx <= i_x0;
        r_cy <= r_cy + 8'd1;
      end else begin
        r_cx <= r_cx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vmem_fill_engine.sv
// Memory-mapped rectangle fill: register file, read mux, clip arithmetic and run FSM.
module vmem_fill_engine
  import vmem_fill_engine_pkg::*;
#(
  parameter int SCREEN_W = 240,
  parameter int SCREEN_H = 240,
  parameter int SEL_BIT  = FILL_SEL_BIT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_wvalid_i,
  input  logic [31:0] dbus_wdata_i,
  input  logic [3:0]  dbus_wstrb_i,
  output logic [31:0] rdata_o,
  input  logic        cpu_vmem_we_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [15:0] vmem_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [8:0] H_LIM = 9'(SCREEN_H);

  fill_state_e r_state, w_state_nx;
  logic [7:0]  r_x0, r_y0;
  logic [8:0]  r_w, r_h, r_x_end, r_y_end;
  logic [15:0] r_color;
  logic        r_done;
  logic [31:0] r_rdata, w_rdata;

  logic        w_sel, w_cfg_wr, w_ctrl_wr, w_start, w_clr, w_empty, w_load;
  logic        w_advance, w_last, w_done_set;
  logic [1:0]  w_off;
  logic [7:0]  w_cx, w_cy;
  logic        w_unused;

  assign w_sel     = dbus_wvalid_i && dbus_addr_i[SEL_BIT];
  assign w_off     = dbus_addr_i[3:2];
  assign w_cfg_wr  = w_sel && (r_state == S_IDLE);
  assign w_ctrl_wr = w_sel && (w_off == FILL_CTRL) && dbus_wstrb_i[0];
  assign w_start   = w_ctrl_wr && dbus_wdata_i[CTRL_START] && (r_state == S_IDLE);
  assign w_clr     = w_ctrl_wr && dbus_wdata_i[CTRL_CLR_DONE];
  assign w_empty   = ({1'b0, r_x0} >= W_LIM) || ({1'b0, r_y0} >= H_LIM) ||
                     (r_w == 9'd0) || (r_h == 9'd0);
  assign w_load    = w_start && !w_empty;
  assign w_advance = (r_state == S_RUN) && !cpu_vmem_we_i;
  assign w_done_set = (w_start && w_empty) || (w_advance && w_last);
  assign w_unused  = ^{dbus_addr_i, dbus_wdata_i};

  vmem_fill_raster u_raster (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_load   (w_load),
    .i_x0     (r_x0),
    .i_y0     (r_y0),
    .i_x_end  (r_x_end),
    .i_y_end  (r_y_end),
    .i_advance(w_advance),
    .o_cx     (w_cx),
    .o_cy     (w_cy),
    .o_last   (w_last)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_load) w_state_nx = S_RUN;
      S_RUN:  if (w_advance && w_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if (dbus_addr_i[SEL_BIT]) begin
      case (w_off)
        FILL_POS:   w_rdata = {8'h00, r_y0, 8'h00, r_x0};
        FILL_SIZE:  w_rdata = {7'h00, r_h, 7'h00, r_w};
        FILL_COLOR: w_rdata = {16'h0000, r_color};
        default: begin
          w_rdata[CTRL_BUSY] = (r_state == S_RUN);
          w_rdata[CTRL_DONE] = r_done;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nx;
      r_rdata <= w_rdata;
      // Completion wins over a coincident clear.
      if (w_done_set)  r_done <= 1'b1;
      else if (w_clr)  r_done <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
    end else begin
      if (w_cfg_wr && w_off == FILL_POS) begin
        if (dbus_wstrb_i[0]) r_x0 <= dbus_wdata_i[7:0];
        if (dbus_wstrb_i[2]) r_y0 <= dbus_wdata_i[23:16];
      end
      if (w_cfg_wr && w_off == FILL_SIZE) begin
        if (dbus_wstrb_i[0]) r_w[7:0] <= dbus_wdata_i[7:0];
        if (dbus_wstrb_i[1]) r_w[8]   <= dbus_wdata_i[8];
        if (dbus_wstrb_i[2]) r_h[7:0] <= dbus_wdata_i[23:16];
        if (dbus_wstrb_i[3]) r_h[8]   <= dbus_wdata_i[24];
      end
      if (w_cfg_wr && w_off == FILL_COLOR) begin
        if (dbus_wstrb_i[0]) r_color[7:0]  <= dbus_wdata_i[7:0];
        if (dbus_wstrb_i[1]) r_color[15:8] <= dbus_wdata_i[15:8];
      end
      if (w_load) begin
        r_x_end <= clip_end(r_x0, r_w, W_LIM);
        r_y_end <= clip_end(r_y0, r_h, H_LIM);
      end
    end
  end

  assign rdata_o      = r_rdata;
  assign busy_o       = (r_state == S_RUN);
  assign done_o       = r_done;
  assign vmem_we_o    = (r_state == S_RUN) && !cpu_vmem_we_i;
  assign vmem_addr_o  = {w_cy, w_cx};
  assign vmem_wdata_o = r_color;

endmodule

// File: tb/tb_vmem_fill_engine.sv
// Scoreboard bench for vmem_fill_engine: directed fills, clipping, stalls, done rules, reset.
module tb_vmem_fill_engine;

  localparam logic [31:0] A_POS   = 32'h2000_0000;
  localparam logic [31:0] A_SIZE  = 32'h2000_0004;
  localparam logic [31:0] A_COLOR = 32'h2000_0008;
  localparam logic [31:0] A_CTRL  = 32'h2000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dbus_addr = '0;
  logic        dbus_wvalid = 1'b0;
  logic [31:0] dbus_wdata = '0;
  logic [3:0]  dbus_wstrb = '0;
  logic [31:0] rdata;
  logic        cpu_we = 1'b0;
  logic        vmem_we;
  logic [15:0] vmem_addr, vmem_wdata;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int cyc     = 0;
  int t0;
  int nw;
  logic rd_due = 1'b0;

  logic [31:0] wq[$];
  logic [31:0] rq[$];
  string       rn[$];

  vmem_fill_engine dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .dbus_addr_i  (dbus_addr),
    .dbus_wvalid_i(dbus_wvalid),
    .dbus_wdata_i (dbus_wdata),
    .dbus_wstrb_i (dbus_wstrb),
    .rdata_o      (rdata),
    .cpu_vmem_we_i(cpu_we),
    .vmem_we_o    (vmem_we),
    .vmem_addr_o  (vmem_addr),
    .vmem_wdata_o (vmem_wdata),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected pixel/read response whenever the DUT presents one.
  always @(negedge clk) begin
    if (vmem_we === 1'b1) begin
      n_wr++;
      if (wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", vmem_addr, vmem_wdata);
      end else begin
        chk("vmem_write", {vmem_addr, vmem_wdata}, wq.pop_front());
      end
    end
    if (rd_due) chk(rn.pop_front(), rdata, rq.pop_front());
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(negedge clk);
    dbus_addr = a; dbus_wdata = d; dbus_wstrb = s; dbus_wvalid = 1'b1;
    @(posedge clk);
    #1 dbus_wvalid = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    dbus_addr = a; dbus_wvalid = 1'b0;
    rq.push_back(exp);
    rn.push_back(nm);
    @(posedge clk);
    #1 rd_due = 1'b1;
    @(negedge clk);
    #1 rd_due = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int start, input int exp);
    while (busy && (cyc - start) < 70000) begin
      @(posedge clk);
      #1;
    end
    chk(nm, cyc - start, exp);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_we", {31'b0, vmem_we}, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: 3x2 at (10,20), colour assembled from a byte-lane store
    wr(A_POS, 32'h0014_000A);
    wr(A_SIZE, 32'h0002_0003);
    wr(A_COLOR, 32'h0000_0000);
    wr(A_COLOR, 32'h0000_F8AA, 4'b0010);
    rd("t1_color", A_COLOR, 32'h0000_F800);
    rd("t1_pos", A_POS, 32'h0014_000A);
    wq.push_back(32'h140A_F800); wq.push_back(32'h140B_F800); wq.push_back(32'h140C_F800);
    wq.push_back(32'h150A_F800); wq.push_back(32'h150B_F800); wq.push_back(32'h150C_F800);
    wr(A_CTRL, 32'h1);
    t0 = cyc;
    wait_idle("t1_cycles", t0, 6);
    rd("t1_ctrl", A_CTRL, 32'h2);

    // 2: clipped at the bottom-right corner
    wr(A_CTRL, 32'h2);
    wr(A_POS, 32'h00EF_00EE);
    wr(A_SIZE, 32'h0005_0005);
    wq.push_back(32'hEFEE_F800); wq.push_back(32'hEFEF_F800);
    wr(A_CTRL, 32'h1);
    t0 = cyc;
    wait_idle("t2_cycles", t0, 2);

    // 3: 4x1 with CPU stalls on cycles 2-3
    wr(A_POS, 32'h0005_0000);
    wr(A_SIZE, 32'h0001_0004);
    wq.push_back(32'h0500_F800); wq.push_back(32'h0501_F800);
    wq.push_back(32'h0502_F800); wq.push_back(32'h0503_F800);
    wr(A_CTRL, 32'h1);
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      if (!busy) break;
      cpu_we = (c == 2 || c == 3);
      #1;
      if (c == 2 || c == 3) chk("t3_stall_we", {31'b0, vmem_we}, 0);
      @(posedge clk);
      #1 n++;
    end
    cpu_we = 1'b0;
    chk("t3_cycles", n, 6);

    // 4: zero width, then ignored stores during a full-screen fill
    wr(A_CTRL, 32'h2);
    rd("t4_ctrl_clr", A_CTRL, 32'h0);
    wr(A_SIZE, 32'h0005_0000);
    nw = n_wr;
    wr(A_CTRL, 32'h1);
    rd("t4_ctrl_empty", A_CTRL, 32'h2);
    chk("t4_no_writes", n_wr - nw, 0);
    wr(A_POS, 32'h0);
    wr(A_SIZE, 32'h00F0_00F0);
    wr(A_COLOR, 32'h07E0);
    wr(A_CTRL, 32'h2);
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 240; x++) wq.push_back({y[7:0], x[7:0], 16'h07E0});
    wr(A_CTRL, 32'h1);
    t0 = cyc;
    wr(A_COLOR, 32'h001F);
    wr(A_CTRL, 32'h1);
    wr(A_POS, 32'h0001_0001);
    rd("t4_color_kept", A_COLOR, 32'h07E0);
    rd("t4_ctrl_busy", A_CTRL, 32'h1);
    wait_idle("t4_cycles", t0, 57600);

    // 5: completion vs clear-done, then start with clear-done
    wr(A_CTRL, 32'h2);
    wr(A_POS, 32'h0004_0003);
    wr(A_SIZE, 32'h0001_0001);
    wq.push_back(32'h0403_07E0);
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h2);
    rd("t5_set_wins", A_CTRL, 32'h2);
    wq.push_back(32'h0403_07E0);
    wr(A_CTRL, 32'h3);
    t0 = cyc;
    chk("t5_busy", {31'b0, busy}, 1);
    chk("t5_done_clr", {31'b0, done}, 0);
    wait_idle("t5_cycles", t0, 1);
    rd("t5_ctrl_end", A_CTRL, 32'h2);

    // 6: reset mid-fill
    wr(A_POS, 32'h0);
    wr(A_SIZE, 32'h000A_000A);
    wr(A_COLOR, 32'h1234);
    for (int x = 0; x < 5; x++) wq.push_back({8'h00, x[7:0], 16'h1234});
    wr(A_CTRL, 32'h1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("t6_we_rst", {31'b0, vmem_we}, 0);
    chk("t6_busy_rst", {31'b0, busy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rd("t6_pos", A_POS, 32'h0);
    rd("t6_size", A_SIZE, 32'h0);
    rd("t6_color", A_COLOR, 32'h0);
    rd("t6_ctrl", A_CTRL, 32'h0);
    nw = n_wr;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_writes", n_wr - nw, 0);
    chk("sb_drained", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
